// File: rtl/adder_accumulator.sv
// Multi-operand accumulator behind the 4-bit adder: sums NUM_OPS operands per result
// with a sticky carry. Define ADDER_ACCUM_SATURATE_EN to clamp s to all ones on overflow.
module adder_accumulator #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [3:0]       op_cnt
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] s_next;
  logic             cout_next;
  logic [3:0]       cnt_next;
  logic             first_op;
  logic [WIDTH-1:0] add_a;
  logic             add_cin;
  logic [WIDTH:0]   add_full;

  // The first operand of a result starts from zero, so stale s and cout never leak in.
  always_comb begin
    first_op = (op_cnt == 4'd0);
    add_a    = first_op ? '0 : s;
    add_cin  = first_op & cin;
    add_full = {1'b0, add_a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    cout_next  = cout;
    cnt_next   = op_cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_next    = add_full[WIDTH-1:0];
          cout_next = first_op ? add_full[WIDTH] : (cout | add_full[WIDTH]);
`ifdef ADDER_ACCUM_SATURATE_EN
          // Sticky carry doubles as the saturation flag for the rest of the result.
          if (cout_next) begin
            s_next = '1;
          end
`endif
          cnt_next = op_cnt + 4'd1;
          if (op_cnt == LAST_OP) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACC;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACC;
      s      <= '0;
      cout   <= 1'b0;
      op_cnt <= 4'd0;
    end else begin
      state  <= state_next;
      s      <= s_next;
      cout   <= cout_next;
      op_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator: directed table, multi-cycle corner sequences and
// randomized results checked against an arithmetic model (total of operands plus cin).
module tb_adder_accumulator;

  localparam int WIDTH   = 4;
  localparam int NUM_OPS = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [3:0]       op_cnt;

  int checkCount;
  int passCount;

  adder_accumulator #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s(s),
    .cout(cout),
    .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][3:0] ops;
    logic            cin;
    logic [3:0]      expWrap;
    logic [3:0]      expSat;
    logic            expCout;
  } vec_t;

  function automatic vec_t mkVec(input logic [3:0] o0, input logic [3:0] o1,
                                 input logic [3:0] o2, input logic [3:0] o3,
                                 input logic c, input logic [3:0] w,
                                 input logic [3:0] st, input logic co);
    vec_t v;
    v.ops[0]  = o0;
    v.ops[1]  = o1;
    v.ops[2]  = o2;
    v.ops[3]  = o3;
    v.cin     = c;
    v.expWrap = w;
    v.expSat  = st;
    v.expCout = co;
    return v;
  endfunction

  // Any carry within a result happens exactly when the true total exceeds 15.
  function automatic logic [3:0] modelSum(input int total);
`ifdef ADDER_ACCUM_SATURATE_EN
    if (total > 15) return 4'hF;
`endif
    return 4'(total % 16);
  endfunction

  function automatic logic modelCout(input int total);
    return (total > 15);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic c);
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    checkOutput("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    b        = op;
    cin      = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collectResult(input string name, input logic [3:0] expS,
                               input logic expCout, input int holdCycles);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    checkOutput({name, "_out_valid"}, out_valid, 1);
    checkOutput({name, "_s"}, s, expS);
    checkOutput({name, "_cout"}, cout, expCout);
    checkOutput({name, "_op_cnt"}, op_cnt, NUM_OPS);
    checkOutput({name, "_in_ready_low"}, in_ready, 0);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput({name, "_held_s"}, s, expS);
      checkOutput({name, "_held_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, "_release_valid"}, out_valid, 0);
    checkOutput({name, "_release_ready"}, in_ready, 1);
    checkOutput({name, "_release_cnt"}, op_cnt, 0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;

    vecs[0] = mkVec(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'hA, 4'hA, 1'b0);
    vecs[1] = mkVec(4'hF, 4'h1, 4'h0, 4'h0, 1'b1, 4'h1, 4'hF, 1'b1);
    vecs[2] = mkVec(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0);
    vecs[3] = mkVec(4'h8, 4'h8, 4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 1'b1);
    vecs[4] = mkVec(4'h5, 4'h5, 4'h5, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0);
    vecs[5] = mkVec(4'h5, 4'h5, 4'h5, 4'h1, 1'b0, 4'h0, 4'hF, 1'b1);
    vecs[6] = mkVec(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 4'hD, 4'hF, 1'b1);
    vecs[7] = mkVec(4'h3, 4'h0, 4'h0, 4'h1, 1'b0, 4'h4, 4'h4, 1'b0);
    vecs[8] = mkVec(4'h7, 4'h8, 4'h0, 4'h0, 1'b1, 4'h0, 4'hF, 1'b1);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_s", s, 0);
    checkOutput("reset_cout", cout, 0);
    checkOutput("reset_op_cnt", op_cnt, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    // Back-to-back 1,2,3,4 with the result held for five cycles.
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    checkOutput("seq1_partial_valid", out_valid, 0);
    checkOutput("seq1_partial_s", s, 4'h6);
    checkOutput("seq1_partial_cnt", op_cnt, 3);
    applyStimulus(4'h4, 1'b0);
    collectResult("seq1", 4'hA, 1'b0, 5);
    checkOutput("seq1_old_s_kept", s, 4'hA);

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < NUM_OPS; k++) applyStimulus(vecs[v].ops[k], vecs[v].cin);
`ifdef ADDER_ACCUM_SATURATE_EN
      collectResult($sformatf("vec%0d", v), vecs[v].expSat, vecs[v].expCout, 0);
`else
      collectResult($sformatf("vec%0d", v), vecs[v].expWrap, vecs[v].expCout, 0);
`endif
    end

    // Backpressure: an operand offered during HOLD must wait for the next result.
    for (int k = 0; k < NUM_OPS; k++) applyStimulus(4'h1, 1'b0);
    in_valid = 1'b1;
    b        = 4'h7;
    cin      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_cnt_held", op_cnt, 4);
      checkOutput("bp_s_held", s, 4'h4);
      checkOutput("bp_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_valid_fall", out_valid, 0);
    checkOutput("bp_ready_rise", in_ready, 1);
    checkOutput("bp_cnt_clear", op_cnt, 0);
    checkOutput("bp_s_kept", s, 4'h4);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_first_s", s, 4'h7);
    checkOutput("bp_first_cnt", op_cnt, 1);
    for (int k = 1; k < NUM_OPS; k++) applyStimulus(4'h0, 1'b0);
    collectResult("bp", 4'h7, 1'b0, 0);

    // Gapped input; out_ready high during ACC must be ignored.
    applyStimulus(4'h2, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("gap_s_idle", s, 4'h2);
      checkOutput("gap_cnt_idle", op_cnt, 1);
      checkOutput("gap_ready_idle", in_ready, 1);
    end
    out_ready = 1'b0;
    applyStimulus(4'h2, 1'b0);
    @(negedge clk);
    checkOutput("gap_s_idle2", s, 4'h4);
    checkOutput("gap_cnt_idle2", op_cnt, 2);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h2, 1'b0);
    collectResult("gap", 4'h8, 1'b0, 0);

    // Reset in the middle of accumulation.
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    checkOutput("rstmid_pre_s", s, 4'h5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmid_s", s, 0);
    checkOutput("rstmid_cnt", op_cnt, 0);
    checkOutput("rstmid_cout", cout, 0);
    checkOutput("rstmid_ready", in_ready, 1);
    for (int k = 0; k < NUM_OPS; k++) applyStimulus(4'h1, 1'b0);
    collectResult("rstmid_after", 4'h4, 1'b0, 0);

    // Reset while holding a result with the carry set.
    applyStimulus(4'h8, 1'b0);
    applyStimulus(4'h8, 1'b0);
    applyStimulus(4'h0, 1'b0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("rsthold_pre_valid", out_valid, 1);
    checkOutput("rsthold_pre_cout", cout, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rsthold_valid", out_valid, 0);
    checkOutput("rsthold_s", s, 0);
    checkOutput("rsthold_cout", cout, 0);
    checkOutput("rsthold_cnt", op_cnt, 0);
    checkOutput("rsthold_ready", in_ready, 1);

    // Randomized results against the arithmetic model.
    for (int r = 0; r < 30; r++) begin
      int   total;
      logic c;
      logic [3:0] op;
      c     = 1'($urandom_range(0, 1));
      total = c;
      for (int k = 0; k < NUM_OPS; k++) begin
        op    = 4'($urandom_range(0, 15));
        total = total + op;
        applyStimulus(op, (k == 0) ? c : 1'($urandom_range(0, 1)));
        if (k < NUM_OPS - 1) repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      collectResult($sformatf("rand%0d", r), modelSum(total), modelCout(total),
                    $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/adder_accumulator.md
Name: adder_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit adder. It consumes one operand per accepted beat and feeds it, with the running total, to the 4-bit add (a = running sum, b = operand).
- It registers the sum (s) and the carry-out (cout) each beat, and reports a completed total after NUM_OPS operands.
- It provides the lab datapath with multi-operand addition, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 4: data width of operands and accumulator; must match the adder width.
- NUM_OPS, 4: number of operands summed per result (2..15).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: operand present on b.
- in_ready, output, 1: block can accept an operand.
- b, input, WIDTH: operand.
- cin, input, 1: carry-in applied to the first operand's add only.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- s, output, WIDTH: accumulated sum (the running value while in ACC).
- cout, output, 1: sticky carry, the OR of every add's carry-out in this result.
- op_cnt, output, 4: operands accepted so far for the current result.

Behaviour:
- Reset (rst=1 at posedge):
  - state=ACC, s=0, cout=0, op_cnt=0, out_valid=0, in_ready=1.
  - rst takes priority over all other inputs, including mid-accumulation and while in HOLD.
  - Any partial sum is discarded.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACC, accept when in_valid=1:
  - {c, sum} = s + b + (op_cnt==0 ? cin : 0), computed at WIDTH+1 bits.
  - s<=sum.
  - cout<=cout | c; on the first operand the stale cout is ignored, so cout<=c.
  - op_cnt<=op_cnt+1.
- Sum wrap: a carry-out wraps the sum modulo 2^WIDTH; the carry is recorded only in cout.
- First operand: s is treated as 0 when op_cnt==0, so the first result equals b+cin.
- Transition to HOLD: when op_cnt==NUM_OPS-1 and an operand is accepted, the next state is HOLD.
  - op_cnt then reads NUM_OPS.
  - s and cout hold the final values.
- Latency: the result is visible 1 cycle after the last operand is accepted.
- ACC with in_valid=0: all registers hold.
- HOLD:
  - s, cout and op_cnt are held stable while out_valid=1 and out_ready=0.
  - in_valid is ignored (in_ready=0); an operand offered in HOLD is not consumed.
- HOLD exit (out_ready=1): at that edge, state<=ACC and op_cnt<=0.
  - s and cout keep the old values until the next accept, which overwrites them per the first-operand rule.
  - in_ready rises the cycle after the handshake. Same-cycle result-accept plus operand-accept is not supported.
- out_ready during ACC: ignored.

Optional Feature:
- Macro: ADDER_ACCUM_SATURATE_EN.
- Defined:
  - On any add with c=1, s<=all ones (4'hF) instead of the wrapped sum.
  - Once saturated, s stays at 4'hF for the rest of that result.
  - cout is still set sticky.
- Undefined: modulo-2^WIDTH wrap as above; there is no saturation logic.

Test Plan:
1. Reset, then operands 1,2,3,4 with cin=0 back-to-back, out_ready=0:
   - out_valid rises 1 cycle after the 4th accept.
   - s=4'hA, cout=0, op_cnt=4, in_ready=0.
   - Values stay held for 5 cycles.
2. Operands F,1,0,0 with cin=1:
   - First add gives 0 with c=1; final s=4'h1, cout=1.
   - With ADDER_ACCUM_SATURATE_EN: s=4'hF, cout=1.
3. Backpressure:
   - Hold out_ready=0 for 3 cycles while in_valid=1 with b=7; the operand is not consumed.
   - Pulse out_ready=1: out_valid falls next cycle and in_ready rises.
   - The next result starts from b=7 (s=7 after the first accept).
4. Gapped input:
   - Operands 2,(idle 2 cycles),2,(idle),2,2.
   - s and op_cnt are unchanged during idle cycles; final s=8, cout=0.
5. Reset mid-operation:
   - After 2 accepts (s=5), assert rst for 1 cycle.
   - s=0, op_cnt=0, cout=0, in_ready=1.
   - Operands 1,1,1,1 then give s=4.
6. Reset in HOLD:
   - With out_valid=1, assert rst: out_valid=0 and s=0 next cycle, with no result handshake.
